// File: rtl/kr_scan_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : kr_scan_checker_if
// Purpose  : LED-bus observation and status bundle for kr_scan_checker.
// Revision : 1.0 - initial release
// ============================================================================
interface kr_scan_checker_if #(
    parameter int SWEEP_W = 16
);
    logic [7:0]         leds;
    logic               sample;
    logic               err_clr;
    logic [2:0]         pos;
    logic               dir;
    logic               locked;
    logic               err;
    logic [1:0]         err_code;
    logic [SWEEP_W-1:0] sweep_cnt;

    modport master (
        output leds, sample, err_clr,
        input  pos, dir, locked, err, err_code, sweep_cnt
    );

    modport slave (
        input  leds, sample, err_clr,
        output pos, dir, locked, err, err_code, sweep_cnt
    );
endinterface
`default_nettype wire

// File: rtl/kr_scan_checker.sv
`default_nettype none
// ============================================================================
// Module   : kr_scan_checker
// Purpose  : Checks a one-hot LED scanner for correct back-and-forth motion.
//            Macro KR_STALL_TOLERATE_EN: ignore repeated positions in TRACK.
// Revision : 1.0 - initial release
// ============================================================================
module kr_scan_checker #(
    parameter int SWEEP_W = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    kr_scan_checker_if.slave    bus
);
    typedef enum logic [1:0] {
        ACQ1  = 2'd0,
        ACQ2  = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t             state;
    logic [2:0]         tracked_pos;
    logic               scan_dir;
    logic               lock_flag;
    logic               err_flag;
    logic [1:0]         err_cause;
    logic [SWEEP_W-1:0] bounces;

    logic               one_hot;
    logic [2:0]         new_pos;
    logic [2:0]         expect_pos;
    logic               bounce;
    logic               step_up;
    logic               step_dn;

    always_comb begin
        new_pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.leds[i]) new_pos = 3'(i);
        end
        one_hot = (bus.leds != 8'd0) && ((bus.leds & (bus.leds - 8'd1)) == 8'd0);

        // End points reverse the sweep instead of wrapping
        bounce     = 1'b0;
        expect_pos = tracked_pos;
        if (!scan_dir) begin
            if (tracked_pos == 3'd7) begin
                expect_pos = 3'd6;
                bounce     = 1'b1;
            end else begin
                expect_pos = tracked_pos + 3'd1;
            end
        end else begin
            if (tracked_pos == 3'd0) begin
                expect_pos = 3'd1;
                bounce     = 1'b1;
            end else begin
                expect_pos = tracked_pos - 3'd1;
            end
        end

        step_up = (tracked_pos != 3'd7) && (new_pos == tracked_pos + 3'd1);
        step_dn = (tracked_pos != 3'd0) && (new_pos == tracked_pos - 3'd1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ACQ1;
            tracked_pos <= 3'd0;
            scan_dir    <= 1'b0;
            lock_flag   <= 1'b0;
            err_flag    <= 1'b0;
            err_cause   <= 2'b00;
            bounces     <= '0;
        end else begin
            // A fresh error below overrides this clear
            if (bus.err_clr) err_flag <= 1'b0;

            if (bus.sample) begin
                if (!one_hot) begin
                    err_flag  <= 1'b1;
                    err_cause <= 2'b01;
                    state     <= ACQ1;
                    lock_flag <= 1'b0;
                end else begin
                    case (state)
                        ACQ1: begin
                            tracked_pos <= new_pos;
                            state       <= ACQ2;
                        end
                        ACQ2: begin
                            tracked_pos <= new_pos;
                            if (step_up || step_dn) begin
                                scan_dir  <= step_dn;
                                state     <= TRACK;
                                lock_flag <= 1'b1;
                            end
                        end
                        TRACK: begin
                            if (new_pos == expect_pos) begin
                                tracked_pos <= new_pos;
                                if (bounce) begin
                                    scan_dir <= ~scan_dir;
                                    if (bounces != {SWEEP_W{1'b1}}) bounces <= bounces + SWEEP_W'(1);
                                end
                            end else if (new_pos == tracked_pos) begin
`ifdef KR_STALL_TOLERATE_EN
                                state <= TRACK;
`else
                                err_flag  <= 1'b1;
                                err_cause <= 2'b11;
                                state     <= ACQ2;
                                lock_flag <= 1'b0;
`endif
                            end else begin
                                err_flag    <= 1'b1;
                                err_cause   <= 2'b10;
                                tracked_pos <= new_pos;
                                state       <= ACQ2;
                                lock_flag   <= 1'b0;
                            end
                        end
                        default: begin
                            state     <= ACQ1;
                            lock_flag <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.pos       = tracked_pos;
    assign bus.dir       = scan_dir;
    assign bus.locked    = lock_flag;
    assign bus.err       = err_flag;
    assign bus.err_code  = err_cause;
    assign bus.sweep_cnt = bounces;
endmodule
`default_nettype wire

// File: tb/tb_kr_scan_checker.sv
`default_nettype none
// Self-checking bench for kr_scan_checker: directed scenarios plus random
// traffic compared against a behavioural scanner model.
module tb_kr_scan_checker;
    localparam int SW = 4;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    kr_scan_checker_if #(.SWEEP_W(SW)) bus ();

    kr_scan_checker #(.SWEEP_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: stage 0 = nothing seen, 1 = one position seen, 2 = tracking
    int     m_stage;
    int     m_pos;
    bit     m_dir;
    bit     m_err;
    int     m_code;
    int     m_sweep;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_next();
        int n;
        n = m_dir ? m_pos - 1 : m_pos + 1;
        if (n > 7) n = 6;
        if (n < 0) n = 1;
        return n;
    endfunction

    function automatic void model_step(input logic [7:0] l, input bit s, input bit c);
        int p;
        int n;
        if (c) m_err = 1'b0;
        if (!s) return;
        if ($countones(l) != 1) begin
            m_err = 1'b1; m_code = 1; m_stage = 0;
            return;
        end
        p = $clog2(l);
        if (m_stage == 0) begin
            m_pos = p; m_stage = 1;
        end else if (m_stage == 1) begin
            if (p == m_pos + 1 || p == m_pos - 1) begin
                m_dir = (p < m_pos); m_stage = 2;
            end
            m_pos = p;
        end else begin
            n = model_next();
            if (p == n) begin
                if ((m_pos == 7 && !m_dir) || (m_pos == 0 && m_dir)) begin
                    m_dir = !m_dir;
                    if (m_sweep < (1 << SW) - 1) m_sweep++;
                end
                m_pos = p;
            end else if (p == m_pos) begin
`ifndef KR_STALL_TOLERATE_EN
                m_err = 1'b1; m_code = 3; m_stage = 1;
`endif
            end else begin
                m_err = 1'b1; m_code = 2; m_pos = p; m_stage = 1;
            end
        end
    endfunction

    task automatic check_model();
        chk("pos",       32'(bus.pos),       32'(m_pos));
        chk("dir",       32'(bus.dir),       32'(m_dir));
        chk("locked",    32'(bus.locked),    32'(m_stage == 2));
        chk("err",       32'(bus.err),       32'(m_err));
        chk("err_code",  32'(bus.err_code),  32'(m_code));
        chk("sweep_cnt", 32'(bus.sweep_cnt), 32'(m_sweep));
    endtask

    task automatic cycle(input logic [7:0] l, input bit s, input bit c);
        @(negedge clk);
        bus.leds = l; bus.sample = s; bus.err_clr = c;
        @(posedge clk);
        model_step(l, s, c);
        #1;
        check_model();
    endtask

    task automatic samp(input logic [7:0] l);
        cycle(l, 1'b1, 1'b0);
    endtask

    // Inputs are randomised during reset to show they are ignored
    task automatic do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            reset = 1'b0;
            bus.leds = 8'($urandom); bus.sample = 1'($urandom); bus.err_clr = 1'($urandom);
            @(posedge clk);
            m_stage = 0; m_pos = 0; m_dir = 0; m_err = 0; m_code = 0; m_sweep = 0;
            #1;
            check_model();
        end
        @(negedge clk);
        reset = 1'b1; bus.sample = 1'b0; bus.err_clr = 1'b0;
    endtask

    task automatic lock_to(input int target);
        do_reset();
        for (int k = 0; k <= target; k++) samp(8'(1 << k));
    endtask

    initial begin
        logic [7:0] l;
        int         r;
        tests = 0; fails = 0;
        reset = 1'b0;
        bus.leds = 8'd0; bus.sample = 1'b0; bus.err_clr = 1'b0;
        m_stage = 0; m_pos = 0; m_dir = 0; m_err = 0; m_code = 0; m_sweep = 0;

        do_reset();
        chk("rst_pos",    32'(bus.pos),       32'd0);
        chk("rst_locked", 32'(bus.locked),    32'd0);
        chk("rst_err",    32'(bus.err),       32'd0);
        chk("rst_sweep",  32'(bus.sweep_cnt), 32'd0);

        // Lock and direction
        samp(8'h01);
        samp(8'h02);
        chk("lock_after2", 32'(bus.locked), 32'd1);
        samp(8'h04);
        chk("lock_pos", 32'(bus.pos), 32'd2);
        chk("lock_dir", 32'(bus.dir), 32'd0);
        chk("lock_err", 32'(bus.err), 32'd0);
        cycle(8'h80, 1'b0, 1'b0);
        chk("idle_hold", 32'(bus.pos), 32'd2);

        // Full sweep with two bounces
        do_reset();
        for (int k = 0; k < 8; k++) samp(8'(1 << k));
        for (int k = 6; k >= 0; k--) samp(8'(1 << k));
        samp(8'h02);
        chk("sweep_cnt2", 32'(bus.sweep_cnt), 32'd2);
        chk("sweep_dir",  32'(bus.dir),       32'd0);
        chk("sweep_err",  32'(bus.err),       32'd0);

        // Not one-hot while locked, then clear
        lock_to(3);
        samp(8'h18);
        chk("noh_err",    32'(bus.err),      32'd1);
        chk("noh_code",   32'(bus.err_code), 32'd1);
        chk("noh_locked", 32'(bus.locked),   32'd0);
        cycle(8'h00, 1'b0, 1'b1);
        chk("clr_err",  32'(bus.err),      32'd0);
        chk("clr_code", 32'(bus.err_code), 32'd1);

        // Wrong step
        lock_to(4);
        samp(8'h04);
        chk("ws_err",    32'(bus.err),      32'd1);
        chk("ws_code",   32'(bus.err_code), 32'd2);
        chk("ws_pos",    32'(bus.pos),      32'd2);
        chk("ws_locked", 32'(bus.locked),   32'd0);
        samp(8'h08);
        chk("ws_relock", 32'(bus.locked), 32'd1);
        chk("ws_dir",    32'(bus.dir),    32'd0);

        // Stall
        lock_to(5);
        samp(8'h20);
        chk("stall_pos", 32'(bus.pos), 32'd5);
`ifdef KR_STALL_TOLERATE_EN
        chk("stall_err",    32'(bus.err),    32'd0);
        chk("stall_locked", 32'(bus.locked), 32'd1);
`else
        chk("stall_err",    32'(bus.err),      32'd1);
        chk("stall_code",   32'(bus.err_code), 32'd3);
        chk("stall_locked", 32'(bus.locked),   32'd0);
`endif

        // Reset mid-sweep, then err_clr loses to a new error
        lock_to(6);
        do_reset();
        chk("mid_rst_pos",    32'(bus.pos),    32'd0);
        chk("mid_rst_locked", 32'(bus.locked), 32'd0);
        cycle(8'h00, 1'b1, 1'b1);
        chk("prio_err",  32'(bus.err),      32'd1);
        chk("prio_code", 32'(bus.err_code), 32'd1);
        samp(8'h10);
        chk("reacq_locked", 32'(bus.locked), 32'd0);

        // Saturation of the bounce counter
        do_reset();
        samp(8'h01);
        for (int k = 0; k < 20; k++) begin
            for (int j = 1; j < 8; j++) samp(8'(1 << j));
            for (int j = 6; j >= 0; j--) samp(8'(1 << j));
        end
        chk("sweep_sat", 32'(bus.sweep_cnt), 32'((1 << SW) - 1));

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(199);
            if (r < 2) begin
                do_reset();
            end else begin
                r = $urandom_range(99);
                if (r < 70 && m_stage == 2)      l = 8'(1 << model_next());
                else if (r < 78)                 l = 8'($urandom);
                else if (r < 86 && m_stage > 0)  l = 8'(1 << m_pos);
                else if (r < 93 && m_stage == 1) l = 8'(1 << ((m_pos == 7) ? 6 : m_pos + 1));
                else                             l = 8'(1 << $urandom_range(7));
                cycle(l, $urandom_range(9) != 0, $urandom_range(9) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
